// File: rtl/bram_arb_pkg.sv
// Shared definitions for the BRAM port arbiter: state encoding, byte-enable
// width helper and the byte-lane merge used by read-modify-write.
package bram_arb_pkg;

  localparam logic [0:0] ARB_IDLE = 1'b0;
  localparam logic [0:0] ARB_RMW  = 1'b1;

  function automatic int unsigned be_width(input int unsigned dw);
    return dw / 8;
  endfunction

  function automatic logic [7:0] merge_byte(input logic [7:0] new_b,
                                            input logic [7:0] old_b,
                                            input logic       en);
    return en ? new_b : old_b;
  endfunction

endpackage

// File: rtl/bram_port_arbiter_rr.sv
// NUM_REQ-wide grant with round-robin pointer; with BRAM_ARB_FIXED_PRIORITY_EN
// defined it reduces to a lowest-index-wins priority encoder.
module rr_arbiter
  import bram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant
);

`ifdef BRAM_ARB_FIXED_PRIORITY_EN
  always_comb begin
    logic found;
    found = 1'b0;
    grant = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req[i] && !found) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`else
  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] next_ptr;

  // Search starts at ptr; the pointer moves to one past the winner.
  always_comb begin
    logic        found;
    int unsigned idx;
    found    = 1'b0;
    idx      = 0;
    grant    = '0;
    next_ptr = ptr;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(ptr) + k) % NUM_REQ;
      if (req[idx] && !found) begin
        grant[idx] = 1'b1;
        next_ptr   = PTR_W'((idx + 1) % NUM_REQ);
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      ptr <= '0;
    else if (advance)
      ptr <= next_ptr;
  end
`endif

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one BRAM port between NUM_REQ requesters; partial writes run as
// read-modify-write. Optional macro: BRAM_ARB_FIXED_PRIORITY_EN.
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned NUM_REQ    = 2
) (
  input  logic                                   CLK,
  input  logic                                   RST_N,
  input  logic [NUM_REQ-1:0]                     REQ_VALID,
  output logic [NUM_REQ-1:0]                     REQ_READY,
  input  logic [NUM_REQ-1:0]                     REQ_WE,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]          REQ_ADDR,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]          REQ_WDATA,
  input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0]      REQ_BE,
  output logic [NUM_REQ-1:0]                     RSP_VALID,
  output logic [DATA_WIDTH-1:0]                  RSP_RDATA,
  output logic                                   RAM_EN,
  output logic                                   RAM_RE,
  output logic                                   RAM_WE,
  output logic [ADDR_WIDTH-1:0]                  RAM_ADDR,
  output logic [DATA_WIDTH-1:0]                  RAM_DI,
  input  logic [DATA_WIDTH-1:0]                  RAM_DO,
  input  logic                                   RAM_DO_VALID
);

  localparam int unsigned BE_WIDTH = be_width(DATA_WIDTH);

  logic [0:0]            state;
  logic [NUM_REQ-1:0]    arb_req;
  logic [NUM_REQ-1:0]    grant;
  logic                  accept;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [BE_WIDTH-1:0]   sel_be;
  logic                  be_full;
  logic                  be_zero;
  logic                  partial;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [BE_WIDTH-1:0]   be_q;
  logic [NUM_REQ-1:0]    owner_q;
  logic                  own_vld_q;
  logic                  rsp_rd_q;
  logic [DATA_WIDTH-1:0] rsp_word_q;
  logic [DATA_WIDTH-1:0] merged;
  logic                  rsp_fire;

  // Reset is folded in so ready stays low while RST_N is held.
  assign arb_req = (state == ARB_IDLE && RST_N) ? REQ_VALID : '0;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .req     (arb_req),
    .advance (accept),
    .grant   (grant)
  );

  assign accept    = |grant;
  assign REQ_READY = grant;

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_be    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_we    = REQ_WE[i];
        sel_addr  = REQ_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = REQ_WDATA[i*DATA_WIDTH +: DATA_WIDTH];
        sel_be    = REQ_BE[i*BE_WIDTH +: BE_WIDTH];
      end
    end
  end

  assign be_full = (sel_be == '1);
  assign be_zero = (sel_be == '0);
  assign partial = sel_we && !be_full && !be_zero;

  for (genvar b = 0; b < BE_WIDTH; b++) begin : g_merge
    assign merged[b*8 +: 8] = merge_byte(wdata_q[b*8 +: 8], RAM_DO[b*8 +: 8], be_q[b]);
  end

  always_comb begin
    RAM_EN   = 1'b0;
    RAM_RE   = 1'b0;
    RAM_WE   = 1'b0;
    RAM_ADDR = sel_addr;
    RAM_DI   = sel_wdata;
    if (state == ARB_RMW) begin
      RAM_EN   = 1'b1;
      RAM_WE   = 1'b1;
      RAM_ADDR = addr_q;
      RAM_DI   = merged;
    end else if (accept) begin
      RAM_EN = !sel_we || !be_zero;
      RAM_RE = !sel_we || partial;
      RAM_WE = sel_we && be_full;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= ARB_IDLE;
      owner_q    <= '0;
      own_vld_q  <= 1'b0;
      rsp_rd_q   <= 1'b0;
      rsp_word_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
    end else if (state == ARB_RMW) begin
      state      <= ARB_IDLE;
      own_vld_q  <= 1'b1;
      rsp_rd_q   <= 1'b0;
      rsp_word_q <= merged;
    end else if (accept) begin
      owner_q    <= grant;
      addr_q     <= sel_addr;
      wdata_q    <= sel_wdata;
      be_q       <= sel_be;
      own_vld_q  <= !partial;
      rsp_rd_q   <= !sel_we;
      rsp_word_q <= sel_wdata;
      if (partial)
        state <= ARB_RMW;
    end else begin
      own_vld_q <= 1'b0;
    end
  end

  // Reads wait for the RAM's read-valid; writes answer with the stored word.
  assign rsp_fire  = own_vld_q && (!rsp_rd_q || RAM_DO_VALID);
  assign RSP_VALID = rsp_fire ? owner_q : '0;
  assign RSP_RDATA = rsp_rd_q ? RAM_DO : rsp_word_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: directed cycle table, reset-in-RMW sequence,
// and random traffic against a transaction-level reference model.
module tb_bram_port_arbiter;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [1:0]  REQ_VALID, REQ_READY, REQ_WE, RSP_VALID;
  logic [17:0] REQ_ADDR;
  logic [63:0] REQ_WDATA;
  logic [7:0]  REQ_BE;
  logic [31:0] RSP_RDATA, RAM_DI, RAM_DO;
  logic        RAM_EN, RAM_RE, RAM_WE, RAM_DO_VALID;
  logic [8:0]  RAM_ADDR;

  int n_chk = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  bram_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .NUM_REQ(2)) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_WE(REQ_WE), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .REQ_BE(REQ_BE),
    .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RAM_EN(RAM_EN), .RAM_RE(RAM_RE),
    .RAM_WE(RAM_WE), .RAM_ADDR(RAM_ADDR), .RAM_DI(RAM_DI), .RAM_DO(RAM_DO),
    .RAM_DO_VALID(RAM_DO_VALID)
  );

  function automatic logic [31:0] init_word(input logic [8:0] a);
    case (a)
      9'h010:  return 32'hDEADBEEF;
      9'h011:  return 32'h0BADF00D;
      9'h020:  return 32'h11223344;
      9'h040:  return 32'h55667788;
      default: return 32'hA5C30000 ^ 32'(a);
    endcase
  endfunction

  // Registered read-first RAM port.
  logic [31:0] ram [512];
  bit          written [512];
  always @(posedge CLK) begin
    RAM_DO_VALID <= RAM_EN && RAM_RE;
    if (RAM_EN && RAM_RE)
      RAM_DO <= written[RAM_ADDR] ? ram[RAM_ADDR] : init_word(RAM_ADDR);
    if (RAM_EN && RAM_WE) begin
      ram[RAM_ADDR]     <= RAM_DI;
      written[RAM_ADDR] <= 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  v, we;
    logic [8:0]  a0, a1;
    logic [31:0] d0;
    logic [3:0]  be0;
    logic [1:0]  ready, rsp;
    logic [31:0] rdata;
    bit          chk_rd;
    logic        en, wr;
    logic [31:0] di;
    bit          chk_di;
  } vec_t;

  function automatic vec_t row(logic [1:0] v, logic [1:0] we, logic [8:0] a0, logic [8:0] a1,
                               logic [31:0] d0, logic [3:0] be0, logic [1:0] ready,
                               logic [1:0] rsp, logic [31:0] rdata, bit chk_rd,
                               logic en, logic wr, logic [31:0] di, bit chk_di);
    vec_t r;
    r.v = v; r.we = we; r.a0 = a0; r.a1 = a1; r.d0 = d0; r.be0 = be0;
    r.ready = ready; r.rsp = rsp; r.rdata = rdata; r.chk_rd = chk_rd;
    r.en = en; r.wr = wr; r.di = di; r.chk_di = chk_di;
    return r;
  endfunction

  typedef struct {
    int          due;
    int          owner;
    logic [31:0] data;
    bit          chk;
  } rsp_t;

  vec_t        tbl [18];
  rsp_t        rspq [$];
  logic [31:0] ref_mem [512];
  logic        rv [2];
  logic        rwe [2];
  logic [8:0]  ra [2];
  logic [31:0] rwd [2];
  logic [3:0]  rbe [2];

  task automatic drive_idle();
    REQ_VALID = '0; REQ_WE = '0; REQ_ADDR = '0; REQ_WDATA = '0; REQ_BE = '0;
  endtask

  initial begin
    int   g, ptr;
    bit   busy;
    rsp_t e;
    logic [1:0]  exp_ready, exp_rsp;
    logic [31:0] nw;

    // cycle table: v we a0 a1 d0 be0 | ready rsp rdata chk_rd en we di chk_di
    tbl[0]  = row(2'b00, 2'b00, 9'h000, 9'h000, 32'h0, 4'h0, 2'b00, 2'b00, 32'h0, 0, 0, 0, 32'h0, 0);
`ifdef BRAM_ARB_FIXED_PRIORITY_EN
    tbl[1]  = row(2'b11, 2'b00, 9'h010, 9'h011, 32'h0, 4'h0, 2'b01, 2'b00, 32'h0, 0, 1, 0, 32'h0, 0);
    tbl[2]  = row(2'b11, 2'b00, 9'h010, 9'h011, 32'h0, 4'h0, 2'b01, 2'b01, 32'hDEADBEEF, 1, 1, 0, 32'h0, 0);
    tbl[3]  = row(2'b11, 2'b00, 9'h010, 9'h011, 32'h0, 4'h0, 2'b01, 2'b01, 32'hDEADBEEF, 1, 1, 0, 32'h0, 0);
    tbl[4]  = row(2'b11, 2'b00, 9'h010, 9'h011, 32'h0, 4'h0, 2'b01, 2'b01, 32'hDEADBEEF, 1, 1, 0, 32'h0, 0);
    tbl[5]  = row(2'b00, 2'b00, 9'h000, 9'h000, 32'h0, 4'h0, 2'b00, 2'b01, 32'hDEADBEEF, 1, 0, 0, 32'h0, 0);
`else
    tbl[1]  = row(2'b11, 2'b00, 9'h010, 9'h011, 32'h0, 4'h0, 2'b01, 2'b00, 32'h0, 0, 1, 0, 32'h0, 0);
    tbl[2]  = row(2'b11, 2'b00, 9'h010, 9'h011, 32'h0, 4'h0, 2'b10, 2'b01, 32'hDEADBEEF, 1, 1, 0, 32'h0, 0);
    tbl[3]  = row(2'b11, 2'b00, 9'h010, 9'h011, 32'h0, 4'h0, 2'b01, 2'b10, 32'h0BADF00D, 1, 1, 0, 32'h0, 0);
    tbl[4]  = row(2'b11, 2'b00, 9'h010, 9'h011, 32'h0, 4'h0, 2'b10, 2'b01, 32'hDEADBEEF, 1, 1, 0, 32'h0, 0);
    tbl[5]  = row(2'b00, 2'b00, 9'h000, 9'h000, 32'h0, 4'h0, 2'b00, 2'b10, 32'h0BADF00D, 1, 0, 0, 32'h0, 0);
`endif
    tbl[6]  = row(2'b01, 2'b00, 9'h010, 9'h000, 32'h0, 4'h0, 2'b01, 2'b00, 32'h0, 0, 1, 0, 32'h0, 0);
    tbl[7]  = row(2'b00, 2'b00, 9'h000, 9'h000, 32'h0, 4'h0, 2'b00, 2'b01, 32'hDEADBEEF, 1, 0, 0, 32'h0, 0);
    tbl[8]  = row(2'b01, 2'b01, 9'h020, 9'h000, 32'h000000AA, 4'h1, 2'b01, 2'b00, 32'h0, 0, 1, 0, 32'h0, 0);
    tbl[9]  = row(2'b10, 2'b00, 9'h000, 9'h020, 32'h0, 4'h0, 2'b00, 2'b00, 32'h0, 0, 1, 1, 32'h112233AA, 1);
    tbl[10] = row(2'b10, 2'b00, 9'h000, 9'h020, 32'h0, 4'h0, 2'b10, 2'b01, 32'h112233AA, 1, 1, 0, 32'h0, 0);
    tbl[11] = row(2'b00, 2'b00, 9'h000, 9'h000, 32'h0, 4'h0, 2'b00, 2'b10, 32'h112233AA, 1, 0, 0, 32'h0, 0);
    tbl[12] = row(2'b01, 2'b01, 9'h030, 9'h000, 32'hCAFEF00D, 4'hF, 2'b01, 2'b00, 32'h0, 0, 1, 1, 32'hCAFEF00D, 1);
    tbl[13] = row(2'b01, 2'b00, 9'h030, 9'h000, 32'h0, 4'h0, 2'b01, 2'b01, 32'hCAFEF00D, 1, 1, 0, 32'h0, 0);
    tbl[14] = row(2'b00, 2'b00, 9'h000, 9'h000, 32'h0, 4'h0, 2'b00, 2'b01, 32'hCAFEF00D, 1, 0, 0, 32'h0, 0);
    tbl[15] = row(2'b01, 2'b01, 9'h030, 9'h000, 32'h12345678, 4'h0, 2'b01, 2'b00, 32'h0, 0, 0, 0, 32'h0, 0);
    tbl[16] = row(2'b01, 2'b00, 9'h030, 9'h000, 32'h0, 4'h0, 2'b01, 2'b01, 32'h0, 0, 1, 0, 32'h0, 0);
    tbl[17] = row(2'b00, 2'b00, 9'h000, 9'h000, 32'h0, 4'h0, 2'b00, 2'b01, 32'hCAFEF00D, 1, 0, 0, 32'h0, 0);

    // Reset with requests pending: everything gated off.
    RST_N = 1'b0;
    drive_idle();
    REQ_VALID = 2'b11;
    REQ_ADDR  = {9'h011, 9'h010};
    @(negedge CLK); @(negedge CLK);
    #1;
    chk("reset_ready", 32'(REQ_READY), 32'h0);
    chk("reset_ram_en", 32'(RAM_EN), 32'h0);
    chk("reset_rsp", 32'(RSP_VALID), 32'h0);
    @(negedge CLK);
    RST_N = 1'b1;

    for (int i = 0; i < 18; i++) begin
      REQ_VALID = tbl[i].v;
      REQ_WE    = tbl[i].we;
      REQ_ADDR  = {tbl[i].a1, tbl[i].a0};
      REQ_WDATA = {32'h0, tbl[i].d0};
      REQ_BE    = {4'h0, tbl[i].be0};
      #1;
      chk($sformatf("row%0d_ready", i), 32'(REQ_READY), 32'(tbl[i].ready));
      chk($sformatf("row%0d_rsp", i), 32'(RSP_VALID), 32'(tbl[i].rsp));
      chk($sformatf("row%0d_ram_en", i), 32'(RAM_EN), 32'(tbl[i].en));
      chk($sformatf("row%0d_ram_we", i), 32'(RAM_WE), 32'(tbl[i].wr));
      if (tbl[i].chk_rd) chk($sformatf("row%0d_rdata", i), RSP_RDATA, tbl[i].rdata);
      if (tbl[i].chk_di) chk($sformatf("row%0d_ram_di", i), RAM_DI, tbl[i].di);
      @(negedge CLK);
    end

    // Reset landing in the RMW cycle abandons the write.
    drive_idle();
    REQ_VALID = 2'b01; REQ_WE = 2'b01; REQ_ADDR = {9'h0, 9'h040};
    REQ_WDATA = {32'h0, 32'h00009900}; REQ_BE = {4'h0, 4'b0010};
    #1 chk("rmwrst_accept", 32'(REQ_READY), 32'h1);
    @(negedge CLK);
    drive_idle();
    #1;
    chk("rmwrst_we", 32'(RAM_WE), 32'h1);
    chk("rmwrst_di", RAM_DI, 32'h55669988);
    RST_N = 1'b0;
    #1;
    chk("rmwrst_we_drop", 32'(RAM_WE), 32'h0);
    chk("rmwrst_en_drop", 32'(RAM_EN), 32'h0);
    @(negedge CLK);
    chk("rmwrst_no_rsp", 32'(RSP_VALID), 32'h0);
    RST_N = 1'b1;
    REQ_VALID = 2'b11; REQ_ADDR = {9'h040, 9'h040};
    #1 chk("rmwrst_first_grant", 32'(REQ_READY), 32'h1);
    @(negedge CLK);
    drive_idle();
    #1;
    chk("rmwrst_rsp", 32'(RSP_VALID), 32'h1);
    chk("rmwrst_mem_kept", RSP_RDATA, 32'h55667788);

    // Fresh reset, then random traffic against the reference model.
    @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 0; i < 512; i++) ref_mem[i] = init_word(9'(i));
    for (int i = 0; i < 2; i++) rv[i] = 1'b0;
    ptr  = 0;
    busy = 1'b0;

    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!rv[i] && c < 1494 && $urandom_range(0, 2) != 0) begin
          int r;
          r      = $urandom_range(0, 17);
          rv[i]  = 1'b1;
          rwe[i] = 1'($urandom_range(0, 1));
          ra[i]  = (r < 16) ? 9'(9'h100 + r) : ((r == 16) ? 9'h1FF : 9'h000);
          rwd[i] = $urandom;
          case ($urandom_range(0, 3))
            0:       rbe[i] = 4'h0;
            1:       rbe[i] = 4'hF;
            default: rbe[i] = 4'($urandom);
          endcase
        end
      end
      REQ_VALID = {rv[1], rv[0]};
      REQ_WE    = {rwe[1], rwe[0]};
      REQ_ADDR  = {ra[1], ra[0]};
      REQ_WDATA = {rwd[1], rwd[0]};
      REQ_BE    = {rbe[1], rbe[0]};

      g = -1;
      if (!busy)
        for (int k = 0; k < 2; k++)
          if (g < 0 && rv[(ptr + k) % 2]) g = (ptr + k) % 2;
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;

      exp_rsp = '0;
      e.chk = 1'b0;
      if (rspq.size() > 0 && rspq[0].due == c) begin
        e = rspq.pop_front();
        exp_rsp[e.owner] = 1'b1;
      end

      #1;
      chk($sformatf("rnd%0d_ready", c), 32'(REQ_READY), 32'(exp_ready));
      chk($sformatf("rnd%0d_rsp", c), 32'(RSP_VALID), 32'(exp_rsp));
      if (exp_rsp != 0 && e.chk) chk($sformatf("rnd%0d_rdata", c), RSP_RDATA, e.data);

      busy = 1'b0;
      if (g >= 0) begin
`ifndef BRAM_ARB_FIXED_PRIORITY_EN
        ptr = (g + 1) % 2;
`endif
        e.owner = g;
        if (!rwe[g]) begin
          e.due = c + 1; e.data = ref_mem[ra[g]]; e.chk = 1'b1;
        end else begin
          nw = ref_mem[ra[g]];
          for (int b = 0; b < 4; b++)
            if (rbe[g][b]) nw[b*8 +: 8] = rwd[g][b*8 +: 8];
          ref_mem[ra[g]] = nw;
          e.data = nw;
          e.chk  = (rbe[g] != 4'h0);
          if (rbe[g] != 4'h0 && rbe[g] != 4'hF) begin
            e.due = c + 2;
            busy  = 1'b1;
          end else begin
            e.due = c + 1;
          end
        end
        rspq.push_back(e);
        rv[g] = 1'b0;
      end
      @(negedge CLK);
    end

    n_chk++;
    if (rspq.size() != 0) begin
      n_err++;
      $display("FAIL rnd_drain: got %0d outstanding expected 0", rspq.size());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
